// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Grants are combinational; ownership bursts are bounded by BURST while the other port waits.
module ram_arbiter #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 256,
    parameter int BURST = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_req,
    input  logic            a_we,
    input  logic [AW-1:0]   a_addr,
    input  logic [SIZE-1:0] a_wdata,
    input  logic            b_req,
    input  logic            b_we,
    input  logic [AW-1:0]   b_addr,
    input  logic [SIZE-1:0] b_wdata,
    output logic            a_gnt,
    output logic            b_gnt,
    output logic            a_rvalid,
    output logic            b_rvalid,
    output logic [SIZE-1:0] rdata,
    output logic [AW-1:0]   ram_address,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    input  logic [SIZE-1:0] ram_read_data
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [7:0] BURST8 = 8'(BURST);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_b_q, last_b_d;
    logic       grant_a, grant_b;
    logic       vld_a_p1, vld_b_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
        end
    end

    // Owner keeps the RAM until its burst is spent while the other port waits.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req && (!b_req || last_b_q)) begin
                    grant_a = 1'b1;
                    state_d = OWN_A;
                    cnt_d   = 8'd1;
                end else if (b_req) begin
                    grant_b = 1'b1;
                    state_d = OWN_B;
                    cnt_d   = 8'd1;
                end
            end
            OWN_A: begin
                if (a_req && (!b_req || cnt_q < BURST8)) begin
                    grant_a = 1'b1;
                    if (cnt_q < BURST8) cnt_d = cnt_q + 8'd1;
                end else if (b_req) begin
                    grant_b = 1'b1;
                    state_d = OWN_B;
                    cnt_d   = 8'd1;
                end else begin
                    state_d  = IDLE;
                    cnt_d    = 8'd0;
                    last_b_d = 1'b0;
                end
            end
            OWN_B: begin
                if (b_req && (!a_req || cnt_q < BURST8)) begin
                    grant_b = 1'b1;
                    if (cnt_q < BURST8) cnt_d = cnt_q + 8'd1;
                end else if (a_req) begin
                    grant_a = 1'b1;
                    state_d = OWN_A;
                    cnt_d   = 8'd1;
                end else begin
                    state_d  = IDLE;
                    cnt_d    = 8'd0;
                    last_b_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Reset holds the RAM quiet even if a request is already pending.
    assign a_gnt = grant_a & rst_n;
    assign b_gnt = grant_b & rst_n;

    always_comb begin
        ram_address    = '0;
        ram_write_data = '0;
        ram_write_en   = 1'b0;
        if (a_gnt) begin
            ram_address    = a_addr;
            ram_write_data = a_wdata;
            ram_write_en   = a_we;
        end else if (b_gnt) begin
            ram_address    = b_addr;
            ram_write_data = b_wdata;
            ram_write_en   = b_we;
        end
    end

    // Stage p1: RAM read data returns one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
        end else begin
            vld_a_p1 <= a_gnt & ~a_we;
            vld_b_p1 <= b_gnt & ~b_we;
        end
    end

    assign a_rvalid = vld_a_p1;
    assign b_rvalid = vld_b_p1;
    assign rdata    = ram_read_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter with a RAM model and a fairness/data reference model.
module tb_ram_arbiter;

    localparam int SIZE  = 8;
    localparam int DEPTH = 256;
    localparam int BURST = 4;
    localparam int AW    = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            a_req, a_we, b_req, b_we;
    logic [AW-1:0]   a_addr, b_addr;
    logic [SIZE-1:0] a_wdata, b_wdata;
    logic            a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [SIZE-1:0] rdata;
    logic [AW-1:0]   ram_address;
    logic [SIZE-1:0] ram_write_data;
    logic            ram_write_en;
    logic [SIZE-1:0] ram_read_data;

    ram_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata), .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_write_en(ram_write_en), .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM attached to the arbiter.
    logic [SIZE-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_address] <= ram_write_data;
        ram_read_data <= mem[ram_address];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = nobody, 1 = A, 2 = B.
    logic [SIZE-1:0] exp_mem [DEPTH];
    int   prev = 0;
    int   run  = 0;
    int   last = 2;
    int   last_eg = 0;
    bit   pend_a = 0, pend_b = 0;
    logic [SIZE-1:0] pend_data = '0;

    always @(negedge clk) begin
        int eg;
        if (!rst_n) begin
            chk("rst_a_gnt", a_gnt, 0);
            chk("rst_b_gnt", b_gnt, 0);
            chk("rst_we", ram_write_en, 0);
            chk("rst_a_rvalid", a_rvalid, 0);
            chk("rst_b_rvalid", b_rvalid, 0);
            prev = 0; run = 0; last = 2; last_eg = 0;
            pend_a = 0; pend_b = 0;
        end else begin
            chk("a_rvalid", a_rvalid, pend_a);
            chk("b_rvalid", b_rvalid, pend_b);
            if (pend_a || pend_b) chk("rdata", rdata, pend_data);

            if (!a_req && !b_req)     eg = 0;
            else if (a_req && !b_req) eg = 1;
            else if (!a_req)          eg = 2;
            else if (prev == 0)       eg = (last == 2) ? 1 : 2;
            else if (run < BURST)     eg = prev;
            else                      eg = 3 - prev;

            chk("a_gnt", a_gnt, eg == 1);
            chk("b_gnt", b_gnt, eg == 2);
            if (eg == 0) begin
                chk("idle_we", ram_write_en, 0);
                chk("idle_addr", ram_address, 0);
                chk("idle_wdata", ram_write_data, 0);
            end else begin
                chk("ram_we", ram_write_en, (eg == 1) ? a_we : b_we);
                chk("ram_addr", ram_address, (eg == 1) ? a_addr : b_addr);
                chk("ram_wdata", ram_write_data, (eg == 1) ? a_wdata : b_wdata);
            end

            pend_a = (eg == 1) && !a_we;
            pend_b = (eg == 2) && !b_we;
            if (eg == 1) begin
                pend_data = exp_mem[a_addr];
                if (a_we) exp_mem[a_addr] = a_wdata;
            end else if (eg == 2) begin
                pend_data = exp_mem[b_addr];
                if (b_we) exp_mem[b_addr] = b_wdata;
            end

            if (eg == 0) begin
                if (prev != 0) last = prev;
                prev = 0; run = 0;
            end else if (eg == prev) begin
                run++;
            end else begin
                prev = eg; run = 1;
            end
            last_eg = eg;
        end
    end

    task automatic idle_all();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_all();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        string s;
        int    n;
        bit    found;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = SIZE'(i * 7 + 1);
            exp_mem[i] = SIZE'(i * 7 + 1);
        end
        rst_n = 0;
        a_req = 1; a_we = 1; a_addr = 9; a_wdata = 8'hEE;
        b_req = 1; b_we = 0; b_addr = 4; b_wdata = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        idle_all();
        rst_n = 1;

        // A writes 0x5A to address 3, then reads it back.
        @(posedge clk); #1;
        a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'h5A;
        @(negedge clk); chk("t1_wr_gnt", a_gnt, 1);
        @(posedge clk); #1; a_we = 0;
        @(negedge clk); chk("t1_rd_gnt", a_gnt, 1);
        @(posedge clk); #1; a_req = 0;
        @(negedge clk);
        chk("t1_rvalid", a_rvalid, 1);
        chk("t1_rdata", rdata, 8'h5A);
        chk("t1_b_rvalid", b_rvalid, 0);

        // First tie after reset goes to A; B follows once A drops.
        do_reset();
        a_req = 1; a_addr = 1; b_req = 1; b_addr = 2;
        @(negedge clk); chk("t2_first_a", a_gnt, 1);
        @(posedge clk); #1; a_req = 0;
        @(negedge clk); chk("t2_then_b", b_gnt, 1);
        @(posedge clk); #1; idle_all();

        // Continuous contention alternates in bursts of four.
        do_reset();
        a_req = 1; a_addr = 1; b_req = 1; b_addr = 2;
        s = "";
        repeat (12) begin
            @(negedge clk);
            s = {s, a_gnt ? "A" : (b_gnt ? "B" : "-")};
            @(posedge clk); #1;
        end
        idle_all();
        n_tests++;
        if (s != "AAAABBBBAAAA") begin
            n_fail++;
            $display("FAIL t3_pattern: got %s expected AAAABBBBAAAA", s);
        end

        // B alone streams without stall, then A gets in within a burst.
        do_reset();
        b_req = 1; b_addr = 6;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (b_gnt) n++;
            @(posedge clk); #1;
        end
        chk("t4_b_run", n, 10);
        a_req = 1; a_addr = 7;
        found = 0;
        for (int i = 0; i < BURST; i++) begin
            @(negedge clk);
            if (a_gnt) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("t4_a_within_burst", found, 1);
        @(posedge clk); #1; idle_all();

        // After A ownership and an idle gap, the next tie goes to B.
        do_reset();
        a_req = 1; a_addr = 8;
        @(posedge clk); #1;
        @(posedge clk); #1; a_req = 0;
        @(posedge clk);
        @(posedge clk); #1;
        a_req = 1; b_req = 1; b_addr = 9;
        @(negedge clk);
        chk("t5_b_first", b_gnt, 1);
        chk("t5_a_waits", a_gnt, 0);
        @(posedge clk); #1; idle_all();

        // Reset right after a B read grant drops the pending read.
        do_reset();
        b_req = 1; b_addr = 5;
        @(negedge clk); chk("t6_b_gnt", b_gnt, 1);
        @(posedge clk); #1;
        b_req = 0; a_req = 1; a_we = 1; a_addr = 5;
        rst_n = 0;
        @(negedge clk);
        chk("t6_b_rvalid", b_rvalid, 0);
        chk("t6_we", ram_write_en, 0);
        @(posedge clk); #1;
        idle_all();
        rst_n = 1;
        repeat (3) begin
            @(negedge clk); chk("t6_no_late_rvalid", b_rvalid, 0);
        end

        // Randomized traffic; requests hold until granted.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (rst_n == 0) rst_n = 1;
            else if ($urandom_range(0, 499) == 0) rst_n = 0;
            if (!(a_req && last_eg != 1)) begin
                a_req   = ($urandom_range(0, 3) != 0);
                a_we    = $urandom_range(0, 1) == 1;
                a_addr  = AW'($urandom_range(0, 7));
                a_wdata = SIZE'($urandom);
            end
            if (!(b_req && last_eg != 2)) begin
                b_req   = ($urandom_range(0, 2) != 0);
                b_we    = $urandom_range(0, 1) == 1;
                b_addr  = AW'($urandom_range(0, 7));
                b_wdata = SIZE'($urandom);
            end
        end
        @(posedge clk); #1;
        rst_n = 1;
        idle_all();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
